// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with run/step/halt debug control.
// Selects the next PC from branch, stall, halt and jump and drives the flushes.
module pc_sequencer #(
   parameter int                NBITS    = 32,
   parameter logic [NBITS-1:0]  RESET_PC = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_step,
   input  logic             i_stall,
   input  logic             i_jump,
   input  logic [NBITS-1:0] i_jump_pc,
   input  logic             i_branch,
   input  logic [NBITS-1:0] i_branch_pc,
   input  logic             i_halt,
   output logic [NBITS-1:0] o_pc,
   output logic             o_pc_write,
   output logic             o_flush_if,
   output logic             o_flush_id,
   output logic [1:0]       o_state,
   output logic             o_halted,
   output logic             o_misaligned,
   output logic [31:0]      o_cycles
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_STEP   = 2'd2,
      S_HALTED = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [NBITS-1:0] pc_q, pc_d;
   logic             mis_q, mis_d;
   logic [31:0]      cyc_q, cyc_d;

   logic             active;
   logic             load;
   logic             halt_taken;
   logic [NBITS-1:0] tgt;
   logic             pc_write, flush_if, flush_id;

   // Reset masks the datapath so combinational outputs are quiet under reset.
   assign active = ((state_q == S_RUN) || (state_q == S_STEP)) && !i_reset;

   always_comb begin
      pc_d       = pc_q;
      mis_d      = mis_q;
      cyc_d      = cyc_q;
      tgt        = '0;
      load       = 1'b0;
      halt_taken = 1'b0;
      pc_write   = 1'b0;
      flush_if   = 1'b0;
      flush_id   = 1'b0;
      if (active) begin
         if (cyc_q != 32'hFFFF_FFFF) begin
            cyc_d = cyc_q + 32'd1;
         end
         if (i_branch) begin
            load     = 1'b1;
            tgt      = i_branch_pc;
            pc_write = 1'b1;
            flush_if = 1'b1;
            flush_id = 1'b1;
         end else if (i_stall) begin
            pc_write = 1'b0;
         end else if (i_halt) begin
            halt_taken = 1'b1;
         end else if (i_jump) begin
            load     = 1'b1;
            tgt      = i_jump_pc;
            pc_write = 1'b1;
            flush_if = 1'b1;
         end else begin
            pc_d     = pc_q + NBITS'(4);
            pc_write = 1'b1;
         end
         if (load) begin
            pc_d  = {tgt[NBITS-1:2], 2'b00};
            mis_d = mis_q | (|tgt[1:0]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_RUN;
            end else if (i_step) begin
               state_d = S_STEP;
            end
         end
         S_RUN: begin
            if (halt_taken) begin
               state_d = S_HALTED;
            end
         end
         S_STEP: begin
            state_d = halt_taken ? S_HALTED : S_IDLE;
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         mis_q   <= 1'b0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         mis_q   <= mis_d;
         cyc_q   <= cyc_d;
      end
   end

   assign o_pc         = pc_q;
   assign o_pc_write   = pc_write;
   assign o_flush_if   = flush_if;
   assign o_flush_id   = flush_id;
   assign o_state      = state_q;
   assign o_halted     = (state_q == S_HALTED);
   assign o_misaligned = mis_q;
   assign o_cycles     = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a per-cycle behavioural reference.
// Literal checks pin the reference at the documented scenarios.
module tb_pc_sequencer;

   logic        i_clk = 1'b0;
   logic        i_reset, i_start, i_step, i_stall;
   logic        i_jump, i_branch, i_halt;
   logic [31:0] i_jump_pc, i_branch_pc;
   logic [31:0] o_pc, o_cycles;
   logic        o_pc_write, o_flush_if, o_flush_id;
   logic [1:0]  o_state;
   logic        o_halted, o_misaligned;

   pc_sequencer dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
      .i_step(i_step), .i_stall(i_stall), .i_jump(i_jump),
      .i_jump_pc(i_jump_pc), .i_branch(i_branch),
      .i_branch_pc(i_branch_pc), .i_halt(i_halt),
      .o_pc(o_pc), .o_pc_write(o_pc_write),
      .o_flush_if(o_flush_if), .o_flush_id(o_flush_id),
      .o_state(o_state), .o_halted(o_halted),
      .o_misaligned(o_misaligned), .o_cycles(o_cycles)
   );

   always #5 i_clk = ~i_clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference state: mode 0 idle, 1 run, 2 single-step, 3 halted.
   int          m_mode  = 0;
   longint      m_pc    = 0;
   bit          m_mis   = 0;
   longint      m_cyc   = 0;
   bit          m_valid = 0;

   function automatic bit m_active();
      return (m_mode == 1 || m_mode == 2) && !i_reset;
   endfunction

   always @(posedge i_clk) begin : model
      int     mode;
      longint pc, tgt, cyc;
      bit     mis, do_load;
      mode = m_mode; pc = m_pc; mis = m_mis; cyc = m_cyc;
      do_load = 0; tgt = 0;
      if (i_reset) begin
         mode = 0; pc = 0; mis = 0; cyc = 0;
      end else if (m_mode == 0) begin
         if (i_start) mode = 1;
         else if (i_step) mode = 2;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (cyc < 64'hFFFF_FFFF) cyc = cyc + 1;
         if (m_mode == 2) mode = 0;
         if (i_branch) begin
            do_load = 1; tgt = longint'(i_branch_pc);
         end else if (i_stall) begin
            pc = m_pc;
         end else if (i_halt) begin
            mode = 3;
         end else if (i_jump) begin
            do_load = 1; tgt = longint'(i_jump_pc);
         end else begin
            pc = (m_pc + 4) % 64'h1_0000_0000;
         end
         if (do_load) begin
            pc = tgt - (tgt % 4);
            if (tgt % 4 != 0) mis = 1;
         end
      end
      m_mode  <= mode;
      m_pc    <= pc;
      m_mis   <= mis;
      m_cyc   <= cyc;
      if (i_reset) m_valid <= 1;
   end

   always @(negedge i_clk) begin : compare
      bit pw, fi, fd;
      pw = 0; fi = 0; fd = 0;
      if (m_active()) begin
         if (i_branch) begin
            pw = 1; fi = 1; fd = 1;
         end else if (i_stall || i_halt) begin
            pw = 0;
         end else begin
            pw = 1; fi = i_jump;
         end
      end
      if (m_valid) begin
         chk("pc", o_pc, 32'(m_pc));
         chk("state", 32'(o_state), 32'(m_mode));
         chk("halted", 32'(o_halted), 32'(m_mode == 3));
         chk("misaligned", 32'(o_misaligned), 32'(m_mis));
         chk("cycles", o_cycles, 32'(m_cyc));
      end
      if (m_valid || i_reset) begin
         chk("pc_write", 32'(o_pc_write), 32'(pw));
         chk("flush_if", 32'(o_flush_if), 32'(fi));
         chk("flush_id", 32'(o_flush_id), 32'(fd));
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr();
      i_start = 0; i_step = 0; i_stall = 0; i_jump = 0;
      i_branch = 0; i_halt = 0;
      i_jump_pc = '0; i_branch_pc = '0;
   endtask

   initial begin
      clr();
      i_reset = 1;
      tick(); tick();
      i_reset = 0; #1;
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_state", 32'(o_state), 32'd0);
      chk("rst_cycles", o_cycles, 32'd0);

      i_start = 1; tick();
      i_start = 0;
      repeat (4) tick();
      chk("run_pc", o_pc, 32'h10);
      chk("run_cycles", o_cycles, 32'd4);
      chk("run_pw", 32'(o_pc_write), 32'd1);

      i_jump = 1; i_jump_pc = 32'h8c02_0002; #1;
      chk("jmp_fi", 32'(o_flush_if), 32'd1);
      chk("jmp_fd", 32'(o_flush_id), 32'd0);
      tick(); clr();
      chk("jmp_pc", o_pc, 32'h8c02_0000);
      chk("jmp_mis", 32'(o_misaligned), 32'd1);

      i_stall = 1; i_jump = 1; i_jump_pc = 32'h100;
      i_branch = 1; i_branch_pc = 32'h40; #1;
      chk("br_fi", 32'(o_flush_if), 32'd1);
      chk("br_fd", 32'(o_flush_id), 32'd1);
      chk("br_pw", 32'(o_pc_write), 32'd1);
      tick(); clr();
      chk("br_pc", o_pc, 32'h40);

      i_branch = 1; i_branch_pc = 32'h20; tick(); clr();
      i_halt = 1; #1;
      chk("halt_pw", 32'(o_pc_write), 32'd0);
      tick(); clr();
      chk("halt_state", 32'(o_state), 32'd3);
      chk("halt_flag", 32'(o_halted), 32'd1);
      i_start = 1; i_step = 1; tick(); tick(); clr();
      chk("halt_pc", o_pc, 32'h20);
      chk("halt_stay", 32'(o_state), 32'd3);
      i_reset = 1; tick(); i_reset = 0;
      chk("rel_pc", o_pc, 32'h0);
      chk("rel_state", 32'(o_state), 32'd0);
      chk("rel_mis", 32'(o_misaligned), 32'd0);

      for (int k = 0; k < 2; k++) begin
         i_step = 1; tick(); i_step = 0; tick();
      end
      chk("idle_pc", o_pc, 32'h8);
      i_step = 1; tick(); i_step = 0;
      chk("step_state", 32'(o_state), 32'd2);
      tick();
      chk("step_pc", o_pc, 32'hC);
      chk("step_back", 32'(o_state), 32'd0);
      repeat (5) tick();
      chk("step_hold", o_pc, 32'hC);
      chk("step_cyc", o_cycles, 32'd3);

      i_start = 1; i_step = 1; tick(); clr();
      chk("both_run", 32'(o_state), 32'd1);
      i_halt = 1; i_stall = 1; tick();
      chk("stall_halt", 32'(o_state), 32'd1);
      chk("stall_pc", o_pc, 32'hC);
      i_stall = 0; tick(); clr();
      chk("halt2", 32'(o_state), 32'd3);

      i_reset = 1; tick(); i_reset = 0;
      i_step = 1; tick(); i_step = 0;
      i_halt = 1; tick(); clr();
      chk("step_halt", 32'(o_state), 32'd3);
      i_reset = 1; tick(); i_reset = 0;

      i_start = 1; tick(); clr();
      i_branch = 1; i_branch_pc = 32'hFFFF_FFFC; tick(); clr();
      chk("wrap_pre", o_pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc", o_pc, 32'h0);

      i_branch = 1; i_branch_pc = 32'h80; i_reset = 1; #1;
      chk("rst_pw", 32'(o_pc_write), 32'd0);
      chk("rst_fi", 32'(o_flush_if), 32'd0);
      chk("rst_fd", 32'(o_flush_id), 32'd0);
      tick(); clr(); i_reset = 0;
      chk("rst2_pc", o_pc, 32'h0);
      chk("rst2_state", 32'(o_state), 32'd0);
      chk("rst2_cyc", o_cycles, 32'd0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
